// File: rtl/sad_pingpong_buffer.sv
// Ping-pong serial-in, parallel-out sample buffer feeding the SAD array.
// Samples are written one per accepted beat into the current write bank.
// A completed bank is presented as one flat vector until the consumer
// releases it, while the other bank keeps loading.
module sad_pingpong_buffer #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 80,
  parameter int PTR_W   = 7,
  parameter int REVERSE = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DEPTH*WIDTH-1:0]   out_data,
  output logic                     out_bank,
  output logic [PTR_W-1:0]         fill_count,
  output logic                     drop
);

  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic             drop_q, drop_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] lane_w;
  logic             accept, rel, wr_en;

  logic [1:0][DEPTH-1:0][WIDTH-1:0] mem;

  // A bank under write is never full, so in_ready only drops when both are full.
  assign in_ready   = ~full_q[wr_bank_q];
  assign out_valid  = full_q[rd_bank_q];
  assign out_bank   = rd_bank_q;
  assign fill_count = wr_ptr_q;
  assign drop       = drop_q;
  assign out_data   = out_valid ? mem[rd_bank_q] : '0;

  assign accept = in_valid & in_ready;
  assign rel    = out_valid & out_ready;
  // flush suppresses the write as well as the control update
  assign wr_en  = accept & ~flush;
  assign lane_w = (REVERSE != 0) ? (LAST - wr_ptr_q) : wr_ptr_q;

  // One storage cell per bank/lane; contents survive reset and flush.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    for (genvar k = 0; k < DEPTH; k++) begin : g_lane
      logic [WIDTH-1:0] cell_q;
      // capture the sample when this bank/lane is the write target
      always_ff @(posedge clk) begin
        if (wr_en && (wr_bank_q == 1'(b)) && (lane_w == PTR_W'(k)))
          cell_q <= in_data;
      end
      assign mem[b][k] = cell_q;
    end
  end

  // Next-state: completion and release hit different banks, so both apply.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_ptr_d  = wr_ptr_q;
    drop_d    = drop_q;
    if (accept) begin
      if (wr_ptr_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_ptr_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    if (in_valid && !in_ready)
      drop_d = 1'b1;
    if (flush) begin
      full_d    = '0;
      wr_bank_d = 1'b0;
      rd_bank_d = 1'b0;
      wr_ptr_d  = '0;
      drop_d    = 1'b0;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_ptr_q  <= '0;
      drop_q    <= 1'b0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_ptr_q  <= wr_ptr_d;
      drop_q    <= drop_d;
    end
  end

endmodule
